// File: rtl/trame_axil_arbiter.sv
// trame_axil_arbiter: two-requester round-robin front end that serialises
// single-word commands onto one AXI4-Lite master port, one at a time.
//
// Ports:
//   ACLK, ARESET         clock, synchronous active-high reset
//   REQn_VALID/READY     command handshake (READY is the grant)
//   REQn_WE/ADDR/WDATA/WSTRB  command fields, held stable until READY
//   REQn_DONE            one-cycle completion pulse to the owner
//   REQn_RDATA/RESP      registered result, held until next completion
//   M_AXI_*              AXI4-Lite master (AW, W, B, AR, R channels)
module trame_axil_arbiter #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,

  input  logic                      REQ0_VALID,
  output logic                      REQ0_READY,
  input  logic                      REQ0_WE,
  input  logic [C_ADDR_WIDTH-1:0]   REQ0_ADDR,
  input  logic [C_DATA_WIDTH-1:0]   REQ0_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] REQ0_WSTRB,
  output logic                      REQ0_DONE,
  output logic [C_DATA_WIDTH-1:0]   REQ0_RDATA,
  output logic [1:0]                REQ0_RESP,

  input  logic                      REQ1_VALID,
  output logic                      REQ1_READY,
  input  logic                      REQ1_WE,
  input  logic [C_ADDR_WIDTH-1:0]   REQ1_ADDR,
  input  logic [C_DATA_WIDTH-1:0]   REQ1_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] REQ1_WSTRB,
  output logic                      REQ1_DONE,
  output logic [C_DATA_WIDTH-1:0]   REQ1_RDATA,
  output logic [1:0]                REQ1_RESP,

  output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  localparam int SW = C_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                    last_grant_q;
  logic                    owner_q;
  logic                    we_q;
  logic [C_ADDR_WIDTH-1:0] addr_q;
  logic [C_DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]           wstrb_q;
  logic                    aw_done_q;
  logic                    w_done_q;

  logic                    done0_q;
  logic                    done1_q;
  logic [C_DATA_WIDTH-1:0] rdata0_q;
  logic [C_DATA_WIDTH-1:0] rdata1_q;
  logic [1:0]              resp0_q;
  logic [1:0]              resp1_q;

  logic                    idle;
  logic                    gnt0;
  logic                    gnt1;
  logic                    gnt;
  logic                    sel_we;
  logic [C_ADDR_WIDTH-1:0] sel_addr;
  logic [C_DATA_WIDTH-1:0] sel_wdata;
  logic [SW-1:0]           sel_wstrb;

  logic                    aw_hs;
  logic                    w_hs;
  logic                    b_hs;
  logic                    r_hs;
  logic                    cmpl;
  logic [1:0]              cmpl_resp;

  // Arbitration. On a tie the requester not served last wins.
  // Grants are suppressed while reset is asserted.
  assign idle = (state_q == IDLE) && !ARESET;

  assign gnt0 = idle && REQ0_VALID &&
                (!REQ1_VALID || last_grant_q);
  assign gnt1 = idle && REQ1_VALID &&
                (!REQ0_VALID || !last_grant_q);
  assign gnt  = gnt0 || gnt1;

  assign sel_we    = gnt1 ? REQ1_WE    : REQ0_WE;
  assign sel_addr  = gnt1 ? REQ1_ADDR  : REQ0_ADDR;
  assign sel_wdata = gnt1 ? REQ1_WDATA : REQ0_WDATA;
  assign sel_wstrb = gnt1 ? REQ1_WSTRB : REQ0_WSTRB;

  assign REQ0_READY = gnt0;
  assign REQ1_READY = gnt1;

  // Master outputs decode only from registers, so no
  // M_AXI input reaches an M_AXI output combinationally.
  assign M_AXI_AWVALID = (state_q == WR) && !aw_done_q;
  assign M_AXI_WVALID  = (state_q == WR) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == WR_RESP);
  assign M_AXI_ARVALID = (state_q == RD_ADDR);
  assign M_AXI_RREADY  = (state_q == RD_DATA);

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs  = M_AXI_BREADY && M_AXI_BVALID;
  assign r_hs  = M_AXI_RREADY && M_AXI_RVALID;

  assign cmpl      = b_hs || r_hs;
  assign cmpl_resp = we_q ? M_AXI_BRESP : M_AXI_RRESP;

  assign REQ0_DONE  = done0_q;
  assign REQ1_DONE  = done1_q;
  assign REQ0_RDATA = rdata0_q;
  assign REQ1_RDATA = rdata1_q;
  assign REQ0_RESP  = resp0_q;
  assign REQ1_RESP  = resp1_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt) begin
          state_d = sel_we ? WR : RD_ADDR;
        end
      end
      WR: begin
        // AW and W may finish in either order or together.
        if ((aw_done_q || aw_hs) &&
            (w_done_q || w_hs)) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command capture and per-channel completion tracking.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      if (gnt) begin
        last_grant_q <= gnt1;
        owner_q      <= gnt1;
        we_q         <= sel_we;
        addr_q       <= sel_addr;
        wdata_q      <= sel_wdata;
        wstrb_q      <= sel_wstrb;
        aw_done_q    <= 1'b0;
        w_done_q     <= 1'b0;
      end
      if (aw_hs) begin
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        w_done_q <= 1'b1;
      end
    end
  end

  // Results return to the owner one cycle after B or R.
  // RDATA is only refreshed by reads.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      resp0_q  <= 2'b00;
      resp1_q  <= 2'b00;
    end else begin
      done0_q <= cmpl && !owner_q;
      done1_q <= cmpl && owner_q;
      if (cmpl && !owner_q) begin
        resp0_q <= cmpl_resp;
        if (r_hs) begin
          rdata0_q <= M_AXI_RDATA;
        end
      end
      if (cmpl && owner_q) begin
        resp1_q <= cmpl_resp;
        if (r_hs) begin
          rdata1_q <= M_AXI_RDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_trame_axil_arbiter.sv
// tb_trame_axil_arbiter: directed scoreboard bench for the arbiter,
// with a small AXI4-Lite register slave that has tunable wait states.
module tb_trame_axil_arbiter;

  logic        clk;
  logic        rst;

  logic        REQ0_VALID, REQ0_READY, REQ0_WE, REQ0_DONE;
  logic [3:0]  REQ0_ADDR, REQ0_WSTRB;
  logic [31:0] REQ0_WDATA, REQ0_RDATA;
  logic [1:0]  REQ0_RESP;
  logic        REQ1_VALID, REQ1_READY, REQ1_WE, REQ1_DONE;
  logic [3:0]  REQ1_ADDR, REQ1_WSTRB;
  logic [31:0] REQ1_WDATA, REQ1_RDATA;
  logic [1:0]  REQ1_RESP;

  logic [3:0]  AWADDR, ARADDR, WSTRB;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY;
  logic        BVALID, BREADY, ARVALID, ARREADY;
  logic        RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;

  trame_axil_arbiter dut (
    .ACLK(clk), .ARESET(rst),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
    .REQ0_WE(REQ0_WE), .REQ0_ADDR(REQ0_ADDR),
    .REQ0_WDATA(REQ0_WDATA), .REQ0_WSTRB(REQ0_WSTRB),
    .REQ0_DONE(REQ0_DONE), .REQ0_RDATA(REQ0_RDATA),
    .REQ0_RESP(REQ0_RESP),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
    .REQ1_WE(REQ1_WE), .REQ1_ADDR(REQ1_ADDR),
    .REQ1_WDATA(REQ1_WDATA), .REQ1_WSTRB(REQ1_WSTRB),
    .REQ1_DONE(REQ1_DONE), .REQ1_RDATA(REQ1_RDATA),
    .REQ1_RESP(REQ1_RESP),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT),
    .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID),
    .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT),
    .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP),
    .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          owner;
    logic        we;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
  } exp_t;

  typedef struct {
    int owner;
    int cyc;
  } gnt_t;

  cmd_t cq0[$];
  cmd_t cq1[$];
  exp_t sb[$];
  gnt_t gq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_n = 0;
  int g0_n = 0;
  int g1_n = 0;
  bit en = 0;
  int aw_dly = 0;
  int w_dly = 0;
  int b_dly = 0;
  bit r_err = 0;
  logic [31:0] last_rd [2];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AXI4-Lite slave model ----------------
  logic [31:0] mem [4];
  int          aw_cnt, w_cnt, b_cnt;
  bit          aw_got, w_got, r_pend;
  logic [1:0]  aw_a, r_a;
  logic [31:0] w_d;
  logic [3:0]  w_s;
  int          aw_n, w_n, ar_n, viol;

  assign AWREADY = AWVALID && !aw_got && (aw_cnt >= aw_dly);
  assign WREADY  = WVALID && !w_got && (w_cnt >= w_dly);
  assign BVALID  = aw_got && w_got && (b_cnt >= b_dly);
  assign BRESP   = 2'b00;
  assign ARREADY = ARVALID && !r_pend;
  assign RVALID  = r_pend;
  assign RDATA   = mem[r_a];
  assign RRESP   = r_err ? 2'b10 : 2'b00;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0;
      w_cnt  <= 0;
      b_cnt  <= 0;
      aw_got <= 0;
      w_got  <= 0;
      r_pend <= 0;
      aw_a   <= 0;
      r_a    <= 0;
      w_d    <= 0;
      w_s    <= 0;
    end else begin
      aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
      b_cnt  <= (aw_got && w_got && !BVALID) ? b_cnt + 1 : 0;
      if (AWVALID && AWREADY) begin
        aw_got <= 1;
        aw_a   <= AWADDR[3:2];
        aw_n   <= aw_n + 1;
      end
      if (WVALID && WREADY) begin
        w_got <= 1;
        w_d   <= WDATA;
        w_s   <= WSTRB;
        w_n   <= w_n + 1;
      end
      if (BVALID && BREADY) begin
        for (int b = 0; b < 4; b++)
          if (w_s[b]) mem[aw_a][b*8 +: 8] <= w_d[b*8 +: 8];
        aw_got <= 0;
        w_got  <= 0;
      end
      if (ARVALID && ARREADY) begin
        r_pend <= 1;
        r_a    <= ARADDR[3:2];
        ar_n   <= ar_n + 1;
      end
      if (RVALID && RREADY) r_pend <= 0;
      // A valid still high after its own handshake.
      if ((AWVALID && aw_got) || (WVALID && w_got))
        viol <= viol + 1;
    end
  end

  // ---------------- requester drivers ----------------
  initial begin
    int c0;
    c0 = 0;
    REQ0_VALID = 0; REQ0_WE = 0; REQ0_ADDR = 0;
    REQ0_WDATA = 0; REQ0_WSTRB = 0;
    forever begin
      @(posedge clk); #1;
      if (g0_n != c0) begin
        c0++;
        void'(cq0.pop_front());
      end
      if (en && cq0.size() > 0) begin
        REQ0_VALID = 1;
        REQ0_WE    = cq0[0].we;
        REQ0_ADDR  = cq0[0].addr;
        REQ0_WDATA = cq0[0].wdata;
        REQ0_WSTRB = 4'hF;
      end else begin
        REQ0_VALID = 0;
      end
    end
  end

  initial begin
    int c1;
    c1 = 0;
    REQ1_VALID = 0; REQ1_WE = 0; REQ1_ADDR = 0;
    REQ1_WDATA = 0; REQ1_WSTRB = 0;
    forever begin
      @(posedge clk); #1;
      if (g1_n != c1) begin
        c1++;
        void'(cq1.pop_front());
      end
      if (en && cq1.size() > 0) begin
        REQ1_VALID = 1;
        REQ1_WE    = cq1[0].we;
        REQ1_ADDR  = cq1[0].addr;
        REQ1_WDATA = cq1[0].wdata;
        REQ1_WSTRB = 4'hF;
      end else begin
        REQ1_VALID = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  exp_t e;
  gnt_t g;

  always @(negedge clk) begin
    if (REQ0_DONE || REQ1_DONE) done_n++;
    if (rst) begin
      gq.delete();
      last_rd[0] = 0;
      last_rd[1] = 0;
    end else begin
      if (REQ0_DONE || REQ1_DONE) begin
        if (sb.size() == 0) begin
          chk("unexp_done", {30'b0, REQ1_DONE, REQ0_DONE}, 0);
        end else begin
          e = sb.pop_front();
          chk("done_owner", {30'b0, REQ1_DONE, REQ0_DONE},
              (e.owner != 0) ? 2 : 1);
          if (gq.size() == 0) begin
            chk("gnt_missing", gq.size(), 1);
          end else begin
            g = gq.pop_front();
            chk("gnt_order", g.owner, e.owner);
            if (e.lat > 0) chk("latency", cyc - g.cyc, e.lat);
          end
          chk("resp", (e.owner != 0) ? REQ1_RESP : REQ0_RESP,
              e.resp);
          if (!e.we) last_rd[e.owner] = e.rdata;
          chk(e.we ? "rdata_hold" : "rdata",
              (e.owner != 0) ? REQ1_RDATA : REQ0_RDATA,
              last_rd[e.owner]);
        end
      end
      if (REQ0_VALID && REQ0_READY) begin
        gq.push_back('{0, cyc});
        g0_n++;
      end
      if (REQ1_VALID && REQ1_READY) begin
        gq.push_back('{1, cyc});
        g1_n++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_cmd(input int n, input logic we,
                          input logic [3:0] a,
                          input logic [31:0] d);
    cmd_t c;
    c = '{we, a, d};
    if (n != 0) cq1.push_back(c);
    else cq0.push_back(c);
  endtask

  task automatic push_exp(input int n, input logic we,
                          input logic [31:0] rd,
                          input logic [1:0] rs, input int lat);
    exp_t x;
    x = '{n, we, rd, rs, lat};
    sb.push_back(x);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((sb.size() > 0 || cq0.size() > 0 || cq1.size() > 0)
           && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_timeout"}, (t < 2000) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int d;
    int a0, w0, r0, v0;
    rst = 1;
    aw_n = 0; w_n = 0; ar_n = 0; viol = 0;
    repeat (3) @(negedge clk);

    chk("rst_valids",
        {23'b0, AWVALID, WVALID, ARVALID, BREADY, RREADY,
         REQ0_READY, REQ1_READY, REQ0_DONE, REQ1_DONE}, 0);
    chk("rst_rdata0", REQ0_RDATA, 0);
    chk("rst_rdata1", REQ1_RDATA, 0);
    chk("rst_resp", {28'b0, REQ0_RESP, REQ1_RESP}, 0);
    chk("rst_addr", {24'b0, AWADDR, ARADDR}, 0);
    chk("rst_wdata", WDATA, 0);
    chk("prot", {26'b0, AWPROT, ARPROT}, 0);
    rst = 0;
    @(negedge clk);

    // Single writer, then read back.
    en = 1;
    d = done_n;
    for (int i = 0; i < 4; i++) begin
      push_exp(0, 1, 0, 0, 3);
      push_cmd(0, 1, 4'(i * 4), 32'(i + 1));
    end
    wait_drain("t1_wr");
    for (int i = 0; i < 4; i++) begin
      push_exp(0, 0, 32'(i + 1), 0, 3);
      push_cmd(0, 0, 4'(i * 4), 0);
    end
    wait_drain("t1_rd");
    chk("t1_dones", done_n - d, 8);

    // Simultaneous requests straight out of reset.
    en = 0;
    do_reset();
    push_exp(0, 1, 0, 0, 3);
    push_exp(1, 1, 0, 0, 3);
    push_cmd(0, 1, 4'h4, 32'hA5A5A5A5);
    push_cmd(1, 1, 4'h4, 32'h5A5A5A5A);
    @(negedge clk);
    en = 1;
    wait_drain("t2_wr");
    push_exp(1, 0, 32'h5A5A5A5A, 0, 3);
    push_cmd(1, 0, 4'h4, 0);
    wait_drain("t2_rd");

    // Sustained contention: REQ0 writes, REQ1 reads back.
    en = 0;
    for (int i = 0; i < 8; i++) begin
      push_exp(0, 1, 0, 0, 3);
      push_exp(1, 0, 32'h100 + 32'(i), 0, 3);
      push_cmd(0, 1, 4'h0, 32'h100 + 32'(i));
      push_cmd(1, 0, 4'h0, 0);
    end
    d = done_n;
    @(negedge clk);
    en = 1;
    wait_drain("t3");
    chk("t3_dones", done_n - d, 16);

    // Backpressure on AW, W and B.
    aw_dly = 3; w_dly = 1; b_dly = 2;
    a0 = aw_n; w0 = w_n; v0 = viol; d = done_n;
    push_exp(0, 1, 0, 0, 8);
    push_cmd(0, 1, 4'h8, 32'hDEADBEEF);
    wait_drain("t4");
    chk("t4_aw_count", aw_n - a0, 1);
    chk("t4_w_count", w_n - w0, 1);
    chk("t4_valid_drop", viol - v0, 0);
    chk("t4_dones", done_n - d, 1);
    aw_dly = 0; w_dly = 0; b_dly = 0;
    push_exp(0, 0, 32'hDEADBEEF, 0, 3);
    push_cmd(0, 0, 4'h8, 0);
    wait_drain("t4_rd");

    // Error response on a REQ1 read.
    r_err = 1;
    r0 = ar_n;
    push_exp(1, 0, 32'h4, 2'b10, 3);
    push_cmd(1, 0, 4'hC, 0);
    wait_drain("t5");
    chk("t5_ar_count", ar_n - r0, 1);
    r_err = 0;

    // Reset while waiting on B.
    b_dly = 20;
    push_cmd(0, 1, 4'h0, 32'h77);
    begin
      int t;
      t = 0;
      while (!BREADY && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("t6_in_wr_resp", {31'b0, BREADY}, 1);
    end
    d = done_n;
    rst = 1;
    @(posedge clk); #1;
    chk("t6_rst_valids",
        {23'b0, AWVALID, WVALID, ARVALID, BREADY, RREADY,
         REQ0_READY, REQ1_READY, REQ0_DONE, REQ1_DONE}, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    b_dly = 0;
    repeat (4) @(negedge clk);
    chk("t6_no_done", done_n - d, 0);
    en = 0;
    push_exp(0, 1, 0, 0, 3);
    push_exp(1, 1, 0, 0, 3);
    push_cmd(0, 1, 4'h0, 32'h11);
    push_cmd(1, 1, 4'h4, 32'h22);
    @(negedge clk);
    en = 1;
    wait_drain("t6_tie");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trame_axil_arbiter.md
# trame_axil_arbiter

Two-requester round-robin arbiter that shares the single AXI4-Lite slave register port (S00_AXI, four 32-bit registers at 0x0/0x4/0x8/0xC) of the trame IP. Each requester issues single-word read or write commands on a simple valid/ready port. The arbiter serialises these commands into AXI4-Lite master transactions, with one outstanding at a time, and returns the response to the originating requester. It sits between the trame control logic and the trame register slave in the block design.

## Interface
- C_ADDR_WIDTH, 4: AXI4-Lite byte address width.
- C_DATA_WIDTH, 32: data width; fixed at 32.

- ACLK  in  1  sole clock; all logic is rising-edge.
- ARESET  in  1  synchronous, active-high reset.
- REQ0_VALID / REQ1_VALID  in  1  command request.
- REQ0_READY / REQ1_READY  out  1  command accepted (grant), combinational in IDLE.
- REQn_WE  in  1  1 = write, 0 = read.
- REQn_ADDR  in  C_ADDR_WIDTH  byte address.
- REQn_WDATA  in  32  write data.
- REQn_WSTRB  in  4  write byte strobes.
- REQn_DONE  out  1  one-cycle completion pulse.
- REQn_RDATA  out  32  read data, valid with DONE.
- REQn_RESP  out  2  AXI response, valid with DONE.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels. AWPROT and ARPROT are tied to 3'b000.

## Operation
- FSM states: IDLE, WR (AW/W phase), WR_RESP, RD_ADDR, RD_DATA.
- IDLE, arbitration:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester not granted last (`last_grant` register).
  - Reset value of `last_grant` = 1, so REQ0 wins the first tie.
- IDLE, on grant:
  - REQn_READY = 1 for exactly that cycle.
  - Latch addr, wdata, wstrb, we and owner id; update `last_grant`.
  - Go to WR if we = 1, else RD_ADDR.
- WR:
  - AWVALID and WVALID rise together.
  - Each drops the cycle after its own handshake; AW and W may complete in either order or together.
  - Once both are done, go to WR_RESP.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP and return to IDLE.
- RD_ADDR: ARVALID = 1 until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID, capture RDATA and RRESP and return to IDLE.
- Completion:
  - Owner's REQn_DONE pulses the cycle after the B or R handshake.
  - REQn_RDATA and REQn_RESP are registered and hold until that requester's next completion.
  - RDATA is left unchanged on write completions.
- Only one transaction is outstanding at any time. No new grant is issued while the FSM is not in IDLE; REQ_READY stays 0 outside IDLE.
- A requester must hold VALID and its command stable until READY. A request dropped before READY is not an error.
- SLVERR and DECERR responses are passed through unchanged. The arbiter does not retry.

## Timing
- Reset:
  - State = IDLE; all VALID/READY outputs, BREADY, RREADY and DONE = 0.
  - REQn_RDATA = 0, REQn_RESP = 0, `last_grant` = 1.
  - Addresses and data = 0.
- Reset mid-transaction: the FSM goes to IDLE and all outputs take reset values at the first edge with ARESET = 1. No DONE is issued for the aborted command. (The slave is reset by the same ARESET.)
- Write latency, zero-wait slave: grant at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2, DONE at cycle 3.
- Read latency, zero-wait slave: grant at cycle 0, AR at cycle 1, R at cycle 2, DONE at cycle 3.
- The earliest next grant is the cycle after the B or R handshake, i.e. concurrent with the DONE pulse.
- No combinational path from any M_AXI input to any M_AXI output.

## Test plan
- Single writer: REQ0 writes 0x00000001..0x00000004 to addresses 0x0..0xC, then reads them back. Required: RDATA matches each value, RESP = 0, four DONE pulses per phase on REQ0 only.
- Simultaneous requests from reset:
  - REQ0 and REQ1 both valid; REQ0 writes 0xA5A5A5A5 to 0x4, REQ1 writes 0x5A5A5A5A to 0x4.
  - Required: REQ0 granted first, then REQ1. A final read of 0x4 returns 0x5A5A5A5A.
- Sustained contention: both requesters hold VALID for 8 commands each. Required: grants strictly alternate 0,1,0,1…; total 16 DONE pulses.
- Backpressure:
  - Slave delays AWREADY by 3 cycles and WREADY by 1 cycle, then BVALID by 2 cycles.
  - Required: AWVALID/WVALID drop independently after their handshakes; one AW and one W only; a single DONE pulse.
- Error response: slave returns RRESP = 2'b10 on a read by REQ1. Required: REQ1_RESP = 2'b10 with DONE; no retry on AR.
- Reset mid-transaction:
  - Assert ARESET while in WR_RESP.
  - Required: all valids = 0 and state IDLE at the next edge; no DONE pulse; after release, REQ0 wins a tie.
